ibr128_stream_master: RTL and testbench

//  Bus master that feeds and drains IBR128_wrapper over its CS/Write/Read/Addr/WData/RData register port.
//  It converts a 32-bit input word stream into 128-bit plaintext blocks and runs each block through the cipher.
//  Per block it: writes PT0..PT3, starts the core via CTRL, polls STA.done, reads CT0..CT3, streams ciphertext out.

---
 rtl/ibr128_stream_master_if.sv | 12 +
 rtl/ibr128_stream_master.sv | 192 +++++++++++++++++++
 tb/tb_ibr128_stream_master.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibr128_stream_master_if.sv
// Register-port bus between ibr128_stream_master and the IBR128 wrapper.
interface ibr128_stream_master_if;
   logic        CS;
   logic        Write;
   logic        Read;
   logic [4:0]  Addr;
   logic [31:0] WData;
   logic [31:0] RData;

   modport master (output CS, Write, Read, Addr, WData, input RData);
   modport slave  (input CS, Write, Read, Addr, WData, output RData);
endinterface

// File: rtl/ibr128_stream_master.sv
// Streams 32-bit words into 128-bit blocks, runs each block through the IBR128
// wrapper over its register port, and streams the ciphertext words back out.
module ibr128_stream_master #(
   parameter int READ_LATENCY = 1,
   parameter int POLL_TIMEOUT = 1024
) (
   input  logic                  Clk,
   input  logic                  RstN,
   input  logic                  start,
   input  logic [15:0]           num_blocks,
   input  logic [127:0]          key,
   input  logic [127:0]          iv,
   input  logic [5:0]            ctrl,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [31:0]           s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [31:0]           m_data,
   ibr128_stream_master_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int PW = $clog2(POLL_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, CFG, COLLECT, GO, POLL, PWAIT, RDCT, EMIT, CLR, FIN
   } state_t;

   state_t          state, state_next;
   logic [127:0]    key_q, iv_q;
   logic [5:0]      ctrl_q;
   logic [15:0]     total, block_cnt;
   logic [2:0]      idx;
   logic [PW-1:0]   poll_cnt;
   logic [7:0]      wait_cnt;
   logic            rd_wait;
   logic            err_q;
   logic [31:0]     ct_buf [4];

   logic wait_last, sta_done, timed_out, last_block;

   assign wait_last  = wait_cnt == 8'(READ_LATENCY - 1);
   assign sta_done   = bus.RData[0];
   assign timed_out  = poll_cnt == PW'(POLL_TIMEOUT);
   assign last_block = (block_cnt + 16'd1) == total;
   assign err        = err_q;

   always_ff @(posedge Clk) begin
      if (!RstN) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (num_blocks == 16'd0) ? FIN : CFG;
         CFG:     if (idx == 3'd7) state_next = COLLECT;
         COLLECT: if (s_valid && idx[1:0] == 2'd3) state_next = GO;
         GO:      state_next = POLL;
         POLL:    state_next = PWAIT;
         PWAIT:   if (wait_last) state_next = sta_done ? RDCT : (timed_out ? CLR : POLL);
         RDCT:    if (rd_wait && wait_last && idx[1:0] == 2'd3) state_next = EMIT;
         EMIT:    if (m_ready && idx[1:0] == 2'd3) state_next = CLR;
         CLR:     state_next = (err_q || last_block) ? FIN : COLLECT;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bus strobes are purely a function of state so a cycle never carries two transactions.
   always_comb begin
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_data    = 32'd0;
      bus.CS    = 1'b0;
      bus.Write = 1'b0;
      bus.Read  = 1'b0;
      bus.Addr  = 5'd0;
      bus.WData = 32'd0;
      busy      = (state != IDLE) && (state != FIN);
      done      = (state == FIN);
      case (state)
         CFG: begin
            bus.CS    = 1'b1;
            bus.Write = 1'b1;
            bus.Addr  = {2'b00, idx};
            bus.WData = idx[2] ? key_q[{idx[1:0], 5'b0} +: 32] : iv_q[{idx[1:0], 5'b0} +: 32];
         end
         COLLECT: begin
            s_ready   = 1'b1;
            bus.CS    = s_valid;
            bus.Write = s_valid;
            bus.Addr  = s_valid ? {3'b010, idx[1:0]} : 5'd0;
            bus.WData = s_valid ? s_data : 32'd0;
         end
         GO: begin
            bus.CS    = 1'b1;
            bus.Write = 1'b1;
            bus.Addr  = 5'h10;
            bus.WData = {26'd0, ctrl_q | 6'h01};
         end
         POLL: begin
            bus.CS   = 1'b1;
            bus.Read = 1'b1;
            bus.Addr = 5'h11;
         end
         RDCT: begin
            bus.CS   = !rd_wait;
            bus.Read = !rd_wait;
            bus.Addr = rd_wait ? 5'd0 : {3'b011, idx[1:0]};
         end
         EMIT: begin
            m_valid = 1'b1;
            m_data  = ct_buf[idx[1:0]];
         end
         CLR: begin
            bus.CS    = 1'b1;
            bus.Write = 1'b1;
            bus.Addr  = 5'h10;
            bus.WData = {26'd0, ctrl_q};
         end
         default: ;
      endcase
   end

   // ctrl bit0 is held at zero here; GO forces Enable on, CLR writes it back off.
   always_ff @(posedge Clk) begin
      if (!RstN) begin
         key_q     <= '0;
         iv_q      <= '0;
         ctrl_q    <= '0;
         total     <= '0;
         block_cnt <= '0;
         idx       <= '0;
         poll_cnt  <= '0;
         wait_cnt  <= '0;
         rd_wait   <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < 4; i++) ct_buf[i] <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               key_q     <= key;
               iv_q      <= iv;
               ctrl_q    <= ctrl & 6'b111110;
               total     <= num_blocks;
               block_cnt <= '0;
               idx       <= '0;
               poll_cnt  <= '0;
               err_q     <= 1'b0;
            end
            CFG:     idx <= idx + 3'd1;
            COLLECT: if (s_valid) idx <= (idx[1:0] == 2'd3) ? 3'd0 : idx + 3'd1;
            POLL: begin
               poll_cnt <= poll_cnt + 1'b1;
               wait_cnt <= '0;
            end
            PWAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (wait_last) begin
                  if (sta_done) poll_cnt <= '0;
                  else if (timed_out) begin
                     err_q    <= 1'b1;
                     poll_cnt <= '0;
                  end
               end
            end
            RDCT: begin
               if (!rd_wait) begin
                  rd_wait  <= 1'b1;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_last) begin
                     ct_buf[idx[1:0]] <= bus.RData;
                     rd_wait          <= 1'b0;
                     idx              <= (idx[1:0] == 2'd3) ? 3'd0 : idx + 3'd1;
                  end
               end
            end
            EMIT: if (m_ready) idx <= (idx[1:0] == 2'd3) ? 3'd0 : idx + 3'd1;
            CLR: begin
               block_cnt <= block_cnt + 16'd1;
               idx       <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ibr128_stream_master.sv
// Bench for ibr128_stream_master with a behavioural wrapper (CT{i}=PT{i}^KEY{i}),
// a stream feeder/drainer and a scoreboard of expected ciphertext words.
module tb_ibr128_stream_master;
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic         RstN, start;
   logic [15:0]  num_blocks;
   logic [127:0] key, iv;
   logic [5:0]   ctrl;
   logic         s_valid, s_ready, m_valid, m_ready;
   logic [31:0]  s_data, m_data;
   logic         busy, done, err;

   ibr128_stream_master_if bus ();

   ibr128_stream_master #(.READ_LATENCY(1), .POLL_TIMEOUT(4)) dut (
      .Clk(Clk), .RstN(RstN), .start(start), .num_blocks(num_blocks),
      .key(key), .iv(iv), .ctrl(ctrl),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .bus(bus), .busy(busy), .done(done), .err(err)
   );

   int compared = 0, mismatched = 0;
   int cycle = 0, job_start = 0, base_done = 0, done_count = 0, last_done_cycle = -1;
   int sta_reads = 0, go_writes = 0, sta_read_cycle = -1;
   int out_count = 0, m_valid_seen = 0;
   bit gap_mode = 0, ready_random = 0, never_done = 0;
   bit feed_accept = 0, m_stall = 0;
   logic [31:0] held_data = '0;
   logic [31:0] regs [32];
   logic        sta = 1'b0;
   int          sta_cnt = 0;
   logic [31:0] rd_next = 32'hDEADBEEF;
   logic [63:0] bus_log[$], trace_ref[$];
   logic [47:0] exp_trace[$];
   logic [31:0] feed_q[$], exp_q[$];

   localparam logic [127:0] PT1 = 128'h123456ab_cd132536_123456ab_cd132536;

   always @(posedge Clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Wrapper model: registers, CTRL-driven STA countdown, read data one cycle after the read.
   always @(negedge Clk) begin
      rd_next = 32'hDEADBEEF;
      if (sta_cnt > 0) begin
         sta_cnt--;
         if (sta_cnt == 0 && !never_done) sta = 1'b1;
      end
      if (bus.CS) begin
         checkOutput("strobe_exclusive", 64'(bus.Write & bus.Read), 64'd0);
         bus_log.push_back({16'(cycle - job_start), bus.Write, bus.Read, 9'd0, bus.Addr,
                            bus.Write ? bus.WData : 32'd0});
         if (bus.Write) begin
            regs[bus.Addr] = bus.WData;
            if (bus.Addr == 5'h10) begin
               sta     = 1'b0;
               sta_cnt = bus.WData[0] ? 5 : 0;
               if (bus.WData[0]) go_writes++;
            end
         end else if (bus.Read) begin
            if (bus.Addr == 5'h11) begin
               rd_next = {31'd0, sta};
               sta_reads++;
               sta_read_cycle = cycle;
            end else if (bus.Addr >= 5'h0C && bus.Addr <= 5'h0F)
               rd_next = regs[bus.Addr - 5'd4] ^ regs[bus.Addr - 5'd8];
            else
               rd_next = regs[bus.Addr];
         end
      end
      if (done) begin
         done_count++;
         last_done_cycle = cycle;
         checkOutput("busy_low_at_done", 64'(busy), 64'd0);
      end
   end

   always @(posedge Clk) bus.RData <= rd_next;

   // Feeder and drainer run just after each edge; the monitor pops the scoreboard per handshake.
   always @(posedge Clk) begin
      #1;
      if (feed_accept) begin
         void'(feed_q.pop_front());
         s_valid = 1'b0;
      end
      if (!s_valid && feed_q.size() > 0 && !(gap_mode && $urandom_range(0, 2) == 0)) begin
         s_valid = 1'b1;
         s_data  = feed_q[0];
      end
      feed_accept = s_valid && s_ready;

      if (m_stall) begin
         checkOutput("m_valid_held", 64'(m_valid), 64'd1);
         checkOutput("m_data_held", 64'(m_data), 64'(held_data));
      end
      m_ready = ready_random ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_valid) m_valid_seen++;
      if (m_valid && m_ready) begin
         out_count++;
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL m_data_unexpected: got %0h expected no word", m_data);
         end else
            checkOutput("m_data", 64'(m_data), 64'(exp_q.pop_front()));
      end
      m_stall   = m_valid && !m_ready;
      held_data = m_data;
   end

   task automatic applyStimulus(input logic [127:0] pt);
      for (int i = 0; i < 4; i++) begin
         feed_q.push_back(pt[32*i +: 32]);
         exp_q.push_back(pt[32*i +: 32] ^ key[32*i +: 32]);
      end
   endtask

   task automatic startJob(input logic [15:0] n);
      @(posedge Clk); #1;
      bus_log.delete();
      sta_reads = 0; go_writes = 0; out_count = 0; m_valid_seen = 0;
      base_done = done_count;
      job_start = cycle;
      num_blocks = n;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
   endtask

   task automatic waitJobEnd(input int budget, input string name);
      int n = 0;
      while (done_count == base_done && n < budget) begin
         @(negedge Clk);
         n++;
      end
      checkOutput({name, "_finished"}, 64'(done_count != base_done), 64'd1);
      repeat (4) @(negedge Clk);
      checkOutput({name, "_done_pulses"}, 64'(done_count - base_done), 64'd1);
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_s_ready"}, 64'(s_ready), 64'd0);
      checkOutput({name, "_m_valid"}, 64'(m_valid), 64'd0);
      checkOutput({name, "_m_data"}, 64'(m_data), 64'd0);
      checkOutput({name, "_strobes"}, 64'({bus.CS, bus.Write, bus.Read}), 64'd0);
      checkOutput({name, "_addr_wdata"}, 64'({bus.Addr, bus.WData}), 64'd0);
      checkOutput({name, "_busy_done_err"}, 64'({busy, done, err}), 64'd0);
   endtask

   task automatic buildExpected(input logic [127:0] pt, input int polls, input bit with_ct);
      exp_trace.delete();
      for (int i = 0; i < 4; i++) exp_trace.push_back({2'b10, 9'd0, 5'(i), iv[32*i +: 32]});
      for (int i = 0; i < 4; i++) exp_trace.push_back({2'b10, 9'd0, 5'(4 + i), key[32*i +: 32]});
      for (int i = 0; i < 4; i++) exp_trace.push_back({2'b10, 9'd0, 5'(8 + i), pt[32*i +: 32]});
      exp_trace.push_back({2'b10, 9'd0, 5'h10, 26'd0, ctrl[5:1], 1'b1});
      for (int p = 0; p < polls; p++) exp_trace.push_back({2'b01, 9'd0, 5'h11, 32'd0});
      if (with_ct)
         for (int i = 0; i < 4; i++) exp_trace.push_back({2'b01, 9'd0, 5'(12 + i), 32'd0});
      exp_trace.push_back({2'b10, 9'd0, 5'h10, 26'd0, ctrl[5:1], 1'b0});
   endtask

   task automatic compareExpected(input string name);
      int n;
      checkOutput({name, "_len"}, 64'(bus_log.size()), 64'(exp_trace.size()));
      n = (bus_log.size() < exp_trace.size()) ? bus_log.size() : exp_trace.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_txn%0d", name, i), 64'(bus_log[i][47:0]), 64'(exp_trace[i]));
   endtask

   task automatic compareRef(input string name);
      int n;
      checkOutput({name, "_len"}, 64'(bus_log.size()), 64'(trace_ref.size()));
      n = (bus_log.size() < trace_ref.size()) ? bus_log.size() : trace_ref.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_txn%0d", name, i), bus_log[i], trace_ref[i]);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      int n;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      RstN = 1'b0; start = 1'b0; num_blocks = '0;
      key  = 128'haabb0918_2736ccdd_99881234_56701122;
      iv   = 128'h11112222_33334444_55556666_77778888;
      ctrl = 6'h2D;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      checkIdle("reset");
      RstN = 1'b1;

      // Single block, no stalls: full bus trace plus ciphertext words.
      applyStimulus(PT1);
      startJob(1);
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      waitJobEnd(400, "single");
      buildExpected(PT1, sta_reads, 1'b1);
      compareExpected("single_trace");
      checkOutput("single_words", 64'(out_count), 64'd4);
      checkOutput("single_err", 64'(err), 64'd0);
      trace_ref = bus_log;

      // Second start while collecting must not perturb the transaction sequence.
      applyStimulus(PT1);
      startJob(1);
      n = 0;
      while (!s_ready && n < 100) begin
         @(posedge Clk); #1;
         n++;
      end
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      waitJobEnd(400, "restart");
      compareRef("restart_trace");

      // Three blocks with input gaps and output backpressure.
      gap_mode = 1; ready_random = 1;
      applyStimulus(128'h0f0f0f0f_00000000_ffffffff_01234567);
      applyStimulus(128'hdeadbeef_a5a5a5a5_5a5a5a5a_13579bdf);
      applyStimulus(128'h11111111_22222222_44444444_88888888);
      startJob(3);
      waitJobEnd(3000, "multi");
      checkOutput("multi_words", 64'(out_count), 64'd12);
      checkOutput("multi_left", 64'(exp_q.size()), 64'd0);
      gap_mode = 0; ready_random = 0;

      // Wrapper never finishes: exactly POLL_TIMEOUT status reads, then abort.
      never_done = 1;
      applyStimulus(PT1);
      startJob(1);
      waitJobEnd(400, "timeout");
      buildExpected(PT1, 4, 1'b0);
      compareExpected("timeout_trace");
      checkOutput("timeout_sta_reads", 64'(sta_reads), 64'd4);
      checkOutput("timeout_err", 64'(err), 64'd1);
      checkOutput("timeout_no_m_valid", 64'(m_valid_seen), 64'd0);
      checkOutput("timeout_unemitted", 64'(exp_q.size()), 64'd4);
      exp_q.delete();
      never_done = 0;

      // Zero blocks: immediate done, no bus traffic, err cleared by start.
      startJob(0);
      waitJobEnd(50, "zero");
      checkOutput("zero_done_latency", 64'(last_done_cycle - job_start), 64'd1);
      checkOutput("zero_bus_txns", 64'(bus_log.size()), 64'd0);
      checkOutput("zero_err", 64'(err), 64'd0);

      // Reset while polling block 2, then a clean single-block job.
      applyStimulus(PT1);
      applyStimulus(128'hcafef00d_0badc0de_feedface_76543210);
      startJob(2);
      found = 0;
      n = 0;
      while (!found && n < 400) begin
         @(posedge Clk); #1;
         n++;
         found = (go_writes == 2) && (sta_read_cycle == cycle - 1);
      end
      checkOutput("reset_reached_pwait", 64'(found), 64'd1);
      RstN = 1'b0;
      @(posedge Clk); #1;
      RstN = 1'b1;
      checkIdle("midjob_reset");
      feed_q.delete();
      exp_q.delete();
      applyStimulus(PT1);
      startJob(1);
      waitJobEnd(400, "after_reset");
      compareRef("after_reset_trace");
      checkOutput("after_reset_words", 64'(out_count), 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
